// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt-entry / RTI-exit sequencer.
// Owns the PSR (privilege, priority, condition codes) and steps the stack-pointer unit,
// R6, MAR, MDR, PC and memory strobes to push PSR+PC onto the supervisor stack, vector
// through the table, and unwind the frame again on RTI.
module lc3_int_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h01,
  parameter logic [2:0] RST_PRI  = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_req,
  input  logic [2:0]  int_pri,
  input  logic [7:0]  int_vec,
  input  logic        boundary,
  input  logic        rti_req,
  input  logic        mem_r,
  input  logic [2:0]  cc_in,
  input  logic [15:0] bus_in,
  output logic [15:0] main_bus,
  output logic        psr_user,
  output logic [2:0]  psr_pri,
  output logic [2:0]  cc_out,
  output logic        LD_CC,
  output logic        LDSavedUSP,
  output logic        LDSavedSSP,
  output logic        GateSP,
  output logic [1:0]  SPMUX,
  output logic        GateR6,
  output logic        GateMDR,
  output logic        GatePC,
  output logic        LD_R6,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_PC,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic        busy,
  output logic        int_ack,
  output logic        rti_done,
  output logic        rti_err
);

  typedef enum logic [4:0] {
    ST_IDLE   = 5'd0,
    ST_E_SWAP = 5'd1,
    ST_E_DEC1 = 5'd2,
    ST_E_PSR  = 5'd3,
    ST_E_WR1  = 5'd4,
    ST_E_DEC2 = 5'd5,
    ST_E_PC   = 5'd6,
    ST_E_WR2  = 5'd7,
    ST_E_VEC  = 5'd8,
    ST_E_RD   = 5'd9,
    ST_E_LDPC = 5'd10,
    ST_R_MAR  = 5'd11,
    ST_R_RD1  = 5'd12,
    ST_R_PC   = 5'd13,
    ST_R_INC  = 5'd14,
    ST_R_RD2  = 5'd15,
    ST_R_PSR  = 5'd16,
    ST_R_POP  = 5'd17,
    ST_R_SWAP = 5'd18
  } state_t;

  localparam logic [1:0] SP_USP = 2'b00;
  localparam logic [1:0] SP_INC = 2'b01;
  localparam logic [1:0] SP_DEC = 2'b10;
  localparam logic [1:0] SP_SSP = 2'b11;

  // Bus image of a PSR: privilege in bit 15, priority in 10:8, N/Z/P in 2:0.
  function automatic logic [15:0] pack_psr(input logic u, input logic [2:0] p, input logic [2:0] c);
    return {u, 4'b0000, p, 5'b00000, c};
  endfunction

  state_t      state_r;
  state_t      next_s;
  logic [7:0]  vec_r;
  logic        saved_user_r;
  logic [2:0]  saved_pri_r;
  logic [2:0]  saved_cc_r;
  logic        psr_user_r;
  logic [2:0]  psr_pri_r;
  logic        accept_s;
  logic        gate_psr_s;
  logic        gate_vec_s;
  logic        unused_bus_s;

  // Only the privilege, priority and CC fields of the read-back bus are meaningful here.
  assign unused_bus_s = ^{bus_in[14:11], bus_in[7:3]};

  // A request is taken only between instructions and only if it outranks the current priority.
  assign accept_s = boundary & int_req & (int_pri > psr_pri_r);

  assign psr_user = psr_user_r;
  assign psr_pri  = psr_pri_r;

  // At most one of the two internal drivers is active; otherwise release the bus.
  assign main_bus = gate_psr_s ? pack_psr(saved_user_r, saved_pri_r, saved_cc_r) :
                    gate_vec_s ? {VEC_BASE, vec_r} : 16'hzzzz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // PSR ownership: snapshot on acceptance, raise priority / drop to supervisor, restore on RTI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr_user_r   <= 1'b0;
      psr_pri_r    <= RST_PRI;
      vec_r        <= 8'h00;
      saved_user_r <= 1'b0;
      saved_pri_r  <= 3'd0;
      saved_cc_r   <= 3'd0;
    end else if ((state_r == ST_IDLE) && accept_s) begin
      vec_r        <= int_vec;
      saved_user_r <= psr_user_r;
      saved_pri_r  <= psr_pri_r;
      saved_cc_r   <= cc_in;
      psr_user_r   <= 1'b0;
      psr_pri_r    <= int_pri;
    end else if (state_r == ST_R_PSR) begin
      psr_user_r   <= bus_in[15];
      psr_pri_r    <= bus_in[10:8];
    end else begin
      psr_user_r   <= psr_user_r;
      psr_pri_r    <= psr_pri_r;
    end
  end

  // Next-state logic and per-state strobes (pulses in IDLE also look at the requests).
  always_comb begin
    next_s     = state_r;
    busy       = (state_r != ST_IDLE);
    gate_psr_s = 1'b0;
    gate_vec_s = 1'b0;
    cc_out     = 3'b000;
    LD_CC      = 1'b0;
    LDSavedUSP = 1'b0;
    LDSavedSSP = 1'b0;
    GateSP     = 1'b0;
    SPMUX      = SP_USP;
    GateR6     = 1'b0;
    GateMDR    = 1'b0;
    GatePC     = 1'b0;
    LD_R6      = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_PC      = 1'b0;
    MEM_EN     = 1'b0;
    MEM_WE     = 1'b0;
    int_ack    = 1'b0;
    rti_done   = 1'b0;
    rti_err    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          int_ack = 1'b1;
          next_s  = psr_user_r ? ST_E_SWAP : ST_E_DEC1;
        end else if (rti_req) begin
          if (psr_user_r) begin
            rti_err = 1'b1;
            next_s  = ST_IDLE;
          end else begin
            next_s  = ST_R_MAR;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_E_SWAP: begin
        LDSavedUSP = 1'b1;
        GateSP     = 1'b1;
        SPMUX      = SP_SSP;
        LD_R6      = 1'b1;
        next_s     = ST_E_DEC1;
      end
      ST_E_DEC1: begin
        GateSP = 1'b1;
        SPMUX  = SP_DEC;
        LD_R6  = 1'b1;
        LD_MAR = 1'b1;
        next_s = ST_E_PSR;
      end
      ST_E_PSR: begin
        gate_psr_s = 1'b1;
        LD_MDR     = 1'b1;
        next_s     = ST_E_WR1;
      end
      ST_E_WR1: begin
        MEM_EN = 1'b1;
        MEM_WE = 1'b1;
        if (mem_r) next_s = ST_E_DEC2;
        else       next_s = ST_E_WR1;
      end
      ST_E_DEC2: begin
        GateSP = 1'b1;
        SPMUX  = SP_DEC;
        LD_R6  = 1'b1;
        LD_MAR = 1'b1;
        next_s = ST_E_PC;
      end
      ST_E_PC: begin
        GatePC = 1'b1;
        LD_MDR = 1'b1;
        next_s = ST_E_WR2;
      end
      ST_E_WR2: begin
        MEM_EN = 1'b1;
        MEM_WE = 1'b1;
        if (mem_r) next_s = ST_E_VEC;
        else       next_s = ST_E_WR2;
      end
      ST_E_VEC: begin
        gate_vec_s = 1'b1;
        LD_MAR     = 1'b1;
        next_s     = ST_E_RD;
      end
      ST_E_RD: begin
        MEM_EN = 1'b1;
        LD_MDR = 1'b1;
        if (mem_r) next_s = ST_E_LDPC;
        else       next_s = ST_E_RD;
      end
      ST_E_LDPC: begin
        GateMDR = 1'b1;
        LD_PC   = 1'b1;
        next_s  = ST_IDLE;
      end
      ST_R_MAR: begin
        GateR6 = 1'b1;
        LD_MAR = 1'b1;
        next_s = ST_R_RD1;
      end
      ST_R_RD1: begin
        MEM_EN = 1'b1;
        LD_MDR = 1'b1;
        if (mem_r) next_s = ST_R_PC;
        else       next_s = ST_R_RD1;
      end
      ST_R_PC: begin
        GateMDR = 1'b1;
        LD_PC   = 1'b1;
        next_s  = ST_R_INC;
      end
      ST_R_INC: begin
        GateSP = 1'b1;
        SPMUX  = SP_INC;
        LD_R6  = 1'b1;
        LD_MAR = 1'b1;
        next_s = ST_R_RD2;
      end
      ST_R_RD2: begin
        MEM_EN = 1'b1;
        LD_MDR = 1'b1;
        if (mem_r) next_s = ST_R_PSR;
        else       next_s = ST_R_RD2;
      end
      ST_R_PSR: begin
        GateMDR = 1'b1;
        cc_out  = bus_in[2:0];
        LD_CC   = 1'b1;
        next_s  = ST_R_POP;
      end
      ST_R_POP: begin
        GateSP = 1'b1;
        SPMUX  = SP_INC;
        LD_R6  = 1'b1;
        // psr_user_r already holds the restored privilege here.
        if (psr_user_r) begin
          next_s = ST_R_SWAP;
        end else begin
          rti_done = 1'b1;
          next_s   = ST_IDLE;
        end
      end
      ST_R_SWAP: begin
        LDSavedSSP = 1'b1;
        GateSP     = 1'b1;
        SPMUX      = SP_USP;
        LD_R6      = 1'b1;
        rti_done   = 1'b1;
        next_s     = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Bench for lc3_int_ctrl: a small datapath (R6, saved SPs, MAR, MDR, PC, memory) reacts
// to the controller strobes; a stack-of-frames reference model predicts the architectural
// outcome of each interrupt / RTI and the bench compares the datapath against it.
module tb_lc3_int_ctrl;

  logic        clk;
  logic        rst_n;
  logic        int_req;
  logic [2:0]  int_pri;
  logic [7:0]  int_vec;
  logic        boundary;
  logic        rti_req;
  logic        mem_r;
  logic [2:0]  cc_in;
  logic [15:0] bus_in;
  wire  [15:0] main_bus;
  logic        psr_user;
  logic [2:0]  psr_pri;
  logic [2:0]  cc_out;
  logic        LD_CC, LDSavedUSP, LDSavedSSP, GateSP, GateR6, GateMDR, GatePC;
  logic [1:0]  SPMUX;
  logic        LD_R6, LD_MAR, LD_MDR, LD_PC, MEM_EN, MEM_WE;
  logic        busy, int_ack, rti_done, rti_err;

  lc3_int_ctrl dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_pri(int_pri), .int_vec(int_vec),
    .boundary(boundary), .rti_req(rti_req), .mem_r(mem_r), .cc_in(cc_in), .bus_in(bus_in),
    .main_bus(main_bus), .psr_user(psr_user), .psr_pri(psr_pri), .cc_out(cc_out), .LD_CC(LD_CC),
    .LDSavedUSP(LDSavedUSP), .LDSavedSSP(LDSavedSSP), .GateSP(GateSP), .SPMUX(SPMUX),
    .GateR6(GateR6), .GateMDR(GateMDR), .GatePC(GatePC), .LD_R6(LD_R6), .LD_MAR(LD_MAR),
    .LD_MDR(LD_MDR), .LD_PC(LD_PC), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .busy(busy),
    .int_ack(int_ack), .rti_done(rti_done), .rti_err(rti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath environment ----------------
  logic [15:0] r6, usp, ssp, pc, mar, mdr, sp_val, dp_bus;
  logic [15:0] dmem [0:65535];
  logic        pl_we, rg_we;
  logic [15:0] pl_addr, pl_data, rg_r6, rg_usp, rg_ssp, rg_pc;
  wire  [19:0] strobes = {LDSavedUSP, LDSavedSSP, GateSP, SPMUX, GateR6, GateMDR, GatePC, LD_R6,
                          LD_MAR, LD_MDR, LD_PC, MEM_EN, MEM_WE, LD_CC, cc_out, int_ack, rti_done};

  always_comb begin
    case (SPMUX)
      2'b00:   sp_val = usp;
      2'b01:   sp_val = r6 + 16'd1;
      2'b10:   sp_val = r6 - 16'd1;
      default: sp_val = ssp;
    endcase
    if (GateSP)       dp_bus = sp_val;
    else if (GateR6)  dp_bus = r6;
    else if (GateMDR) dp_bus = mdr;
    else if (GatePC)  dp_bus = pc;
    else              dp_bus = main_bus;
  end
  assign bus_in = dp_bus;

  always @(posedge clk) begin
    if (pl_we) dmem[pl_addr] <= pl_data;
    else if (MEM_EN && MEM_WE && mem_r) dmem[mar] <= mdr;
    if (rg_we) begin
      r6 <= rg_r6; usp <= rg_usp; ssp <= rg_ssp; pc <= rg_pc;
    end else begin
      if (LDSavedUSP) usp <= r6;
      if (LDSavedSSP) ssp <= r6;
      if (LD_R6)  r6  <= dp_bus;
      if (LD_MAR) mar <= dp_bus;
      if (LD_MDR) mdr <= MEM_EN ? dmem[mar] : dp_bus;
      if (LD_PC)  pc  <= dp_bus;
    end
  end

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_user;
  logic [2:0]  m_pri;
  logic [15:0] m_r6, m_usp, m_ssp, m_pc;
  logic [31:0] frames[$];   // {psr, pc} per pushed frame, top at the back

  // sequence observations
  logic        first_usp, seen_usp, seen_sp11, seen_sp00;
  int          n_done, n_ack_mid, multi, wr1_len, last_cyc;
  logic [2:0]  got_cc;
  logic [15:0] psr_seen, vec_seen;

  function automatic logic [15:0] vt(input logic [7:0] v);
    return {8'h4c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk); #1 pl_we = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_r6"},   {16'd0, r6},   {16'd0, m_r6});
    chk({tag, "_pc"},   {16'd0, pc},   {16'd0, m_pc});
    chk({tag, "_usp"},  {16'd0, usp},  {16'd0, m_usp});
    chk({tag, "_ssp"},  {16'd0, ssp},  {16'd0, m_ssp});
    chk({tag, "_user"}, {31'd0, psr_user}, {31'd0, m_user});
    chk({tag, "_pri"},  {29'd0, psr_pri},  {29'd0, m_pri});
  endtask

  // Follow one busy period, randomising ready/request noise; stall>=0 forces the first write wait.
  task automatic run_seq(input int stall);
    int cyc; int stall_left; bit wr_done;
    cyc = 0; stall_left = stall; wr_done = 1'b0;
    first_usp = 1'b0; seen_usp = 1'b0; seen_sp11 = 1'b0; seen_sp00 = 1'b0;
    n_done = 0; n_ack_mid = 0; multi = 0; wr1_len = 0; got_cc = 3'd0;
    psr_seen = 16'h0; vec_seen = 16'h0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (cyc > 300) break;
      if (cyc == 1) first_usp = LDSavedUSP;
      if (LDSavedUSP) seen_usp = 1'b1;
      if (GateSP && SPMUX == 2'b11) seen_sp11 = 1'b1;
      if (GateSP && SPMUX == 2'b00) seen_sp00 = 1'b1;
      if (LD_CC) got_cc = cc_out;
      if (int_ack) n_ack_mid++;
      if (rti_done) begin n_done++; rti_req = 1'b0; end
      if (int'(GateSP) + int'(GateR6) + int'(GateMDR) + int'(GatePC) > 1) multi++;
      if (LD_MDR && !MEM_EN && !(GateSP | GateR6 | GateMDR | GatePC)) psr_seen = main_bus;
      if (LD_MAR && !(GateSP | GateR6 | GateMDR | GatePC)) vec_seen = main_bus;
      if (MEM_WE && !wr_done) wr1_len++;
      else if (wr1_len > 0) wr_done = 1'b1;
      if (stall >= 0 && MEM_WE && !wr_done) begin
        mem_r = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        mem_r = ($urandom_range(0, 3) != 0);
      end
      int_req  = 1'($urandom_range(0, 1));
      int_pri  = 3'($urandom);
      int_vec  = 8'($urandom);
      boundary = 1'($urandom_range(0, 1));
    end
    int_req = 1'b0; boundary = 1'b0; mem_r = 1'b1;
    last_cyc = cyc;
    chk("seq_bound", {31'd0, cyc <= 300}, 32'd1);
    chk("one_driver", multi, 32'd0);
    chk("no_mid_ack", n_ack_mid, 32'd0);
  endtask

  // Checks and model update after an accepted interrupt sequence.
  task automatic int_after(input string tag, input logic [2:0] pri, input logic [7:0] vec,
                           input logic [2:0] cc);
    logic [15:0] sp, psr;
    sp  = m_user ? m_ssp : m_r6;
    psr = {m_user, 4'b0000, m_pri, 5'b00000, cc};
    chk({tag, "_swap_first"}, {31'd0, first_usp}, {31'd0, m_user});
    chk({tag, "_sp11"}, {31'd0, seen_sp11}, {31'd0, m_user});
    chk({tag, "_psr_bus"}, {16'd0, psr_seen}, {16'd0, psr});
    chk({tag, "_vec_bus"}, {16'd0, vec_seen}, {16'h0001, vec});
    chk({tag, "_mar"}, {16'd0, mar}, {16'h0001, vec});
    chk({tag, "_push_psr"}, {16'd0, dmem[sp - 16'd1]}, {16'd0, psr});
    chk({tag, "_push_pc"},  {16'd0, dmem[sp - 16'd2]}, {16'd0, m_pc});
    if (m_user) m_usp = m_r6;
    frames.push_back({psr, m_pc});
    m_r6 = sp - 16'd2; m_pc = vt(vec); m_user = 1'b0; m_pri = pri;
    check_state(tag);
  endtask

  task automatic rti_after(input string tag);
    logic [31:0] f;
    f = frames.pop_back();
    m_pc = f[15:0]; m_user = f[31]; m_pri = f[26:24]; m_r6 = m_r6 + 16'd2;
    if (m_user) begin m_ssp = m_r6; m_r6 = m_usp; end
    chk({tag, "_done"}, n_done, 32'd1);
    chk({tag, "_cc"}, {29'd0, got_cc}, {29'd0, f[18:16]});
    chk({tag, "_sp00"}, {31'd0, seen_sp00}, {31'd0, m_user});
    check_state(tag);
  endtask

  task automatic do_int(input string tag, input logic [2:0] pri, input logic [7:0] vec, input int stall);
    logic acc; logic [2:0] cc;
    poke({8'h01, vec}, vt(vec));
    @(negedge clk);
    acc = (pri > m_pri);
    cc = 3'($urandom);
    boundary = 1'b1; int_req = 1'b1; int_pri = pri; int_vec = vec; cc_in = cc;
    #1 chk({tag, "_ack"}, {31'd0, int_ack}, {31'd0, acc});
    @(posedge clk); #1 boundary = 1'b0; int_req = 1'b0;
    if (acc) begin
      run_seq(stall);
      chk({tag, "_no_done"}, n_done, 32'd0);
      int_after(tag, pri, vec, cc);
    end else begin
      @(negedge clk);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check_state(tag);
    end
  endtask

  task automatic do_rti(input string tag);
    @(negedge clk);
    rti_req = 1'b1;
    #1;
    if (m_user) begin
      chk({tag, "_err"}, {31'd0, rti_err}, 32'd1);
      chk({tag, "_quiet"}, {12'd0, strobes}, 32'd0);
      @(posedge clk); #1 rti_req = 1'b0;
      @(negedge clk);
      chk({tag, "_err_end"}, {31'd0, rti_err}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check_state(tag);
    end else begin
      chk({tag, "_no_err"}, {31'd0, rti_err}, 32'd0);
      @(posedge clk); #1;
      run_seq(-1);
      rti_after(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] cc;
    int k;
    rst_n = 1'b0; int_req = 1'b0; int_pri = 3'd0; int_vec = 8'h00; boundary = 1'b0;
    rti_req = 1'b0; mem_r = 1'b1; cc_in = 3'd0; pl_we = 1'b0; rg_we = 1'b0;
    pl_addr = 16'h0; pl_data = 16'h0; rg_r6 = 16'h0; rg_usp = 16'h0; rg_ssp = 16'h0; rg_pc = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_user", {31'd0, psr_user}, 32'd0);
    chk("rst_pri", {29'd0, psr_pri}, 32'd0);
    chk("rst_strobes", {12'd0, strobes}, 32'd0);
    chk("rst_err", {31'd0, rti_err}, 32'd0);
    rst_n = 1'b1;

    // Supervisor stack holds one frame returning to user code at x3005 with CC=Z.
    rg_r6 = 16'h3000; rg_usp = 16'hFE00; rg_ssp = 16'h0000; rg_pc = 16'h0200; rg_we = 1'b1;
    @(posedge clk); #1 rg_we = 1'b0;
    poke(16'h3000, 16'h3005);
    poke(16'h3001, 16'h8002);
    m_user = 1'b0; m_pri = 3'd0; m_r6 = 16'h3000; m_usp = 16'hFE00; m_ssp = 16'h0000; m_pc = 16'h0200;
    frames.push_back({16'h8002, 16'h3005});
    do_rti("rti_to_user");
    do_rti("rti_in_user");

    do_int("int_user4", 3'd4, 8'h80, -1);
    do_int("int_nest5", 3'd5, 8'h11, -1);
    do_int("int_low3", 3'd3, 8'h12, -1);
    do_int("int_nest6", 3'd6, 8'h13, -1);
    chk("nest6_no_usp", {31'd0, seen_usp}, 32'd0);
    do_int("int_stall7", 3'd7, 8'h14, 5);
    chk("stall_wr1_len", wr1_len, 32'd6);
    do_rti("rti_p6");
    do_rti("rti_p5");
    do_rti("rti_p4");

    // Interrupt and RTI together: interrupt first, RTI served straight after.
    poke(16'h0122, vt(8'h22));
    @(negedge clk);
    cc = 3'b100;
    boundary = 1'b1; int_req = 1'b1; int_pri = 3'd6; int_vec = 8'h22; cc_in = cc; rti_req = 1'b1;
    #1 chk("both_ack", {31'd0, int_ack}, 32'd1);
    chk("both_no_err", {31'd0, rti_err}, 32'd0);
    @(posedge clk); #1 boundary = 1'b0; int_req = 1'b0;
    run_seq(-1);
    chk("both_int_no_done", n_done, 32'd0);
    int_after("both_int", 3'd6, 8'h22, cc);
    run_seq(-1);
    rti_after("both_rti");

    do_rti("rti_back_user");
    do_rti("rti_user_err");

    // Randomised mix of interrupts and returns.
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0 && (m_user || frames.size() > 0)) do_rti("rnd_rti");
      else do_int("rnd_int", 3'($urandom), 8'($urandom), -1);
    end

    // Reset in the middle of an entry sequence (state E_PC).
    poke(16'h0133, vt(8'h33));
    @(negedge clk);
    boundary = 1'b1; int_req = 1'b1; int_pri = 3'd7; int_vec = 8'h33;
    @(posedge clk); #1 boundary = 1'b0; int_req = 1'b0;
    k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (GatePC || !busy) break;
      k++;
    end
    chk("reach_e_pc", {31'd0, GatePC}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_strobes", {12'd0, strobes}, 32'd0);
    chk("mid_rst_pri", {29'd0, psr_pri}, 32'd0);
    chk("mid_rst_user", {31'd0, psr_user}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
